// File: rtl/bsg_gatestack_strobe_gen.sv
// Feeds a per-lane gated-clock register stack: data bus plus glitch-free per-lane strobes.
// Latency: data_o updates on the accepting edge; strobe rises S cycles later, lasts P, then H hold cycles.
// Backpressure: ready_o is low for S+P+H cycles per transfer; no buffering, so v_i is ignored while busy.
module bsg_gatestack_strobe_gen #(
  parameter int width_p        = 16,
  parameter int setup_cycles_p = 1,
  parameter int pulse_cycles_p = 1,
  parameter int hold_cycles_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] mask_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] strobe_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int MaxSp   = (setup_cycles_p > pulse_cycles_p) ? setup_cycles_p : pulse_cycles_p;
  localparam int MaxCyc  = (MaxSp > hold_cycles_p) ? MaxSp : hold_cycles_p;
  localparam int CntW    = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] SetupLd = CntW'(setup_cycles_p - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(pulse_cycles_p - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(hold_cycles_p - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [width_p-1:0] data_q;
  logic [width_p-1:0] mask_q;
  logic [width_p-1:0] strobe_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  // Sequencer: every output is a flop so strobes can never glitch on input activity;
  // ready/busy are updated alongside the state so they always agree with it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          strobe_q <= '0;
          if (v_i && ready_q) begin
            data_q  <= data_i;
            mask_q  <= mask_i;
            cnt_q   <= SetupLd;
            state_q <= SETUP;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            strobe_q <= mask_q;
            cnt_q    <= PulseLd;
            state_q  <= PULSE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            strobe_q <= '0;
            cnt_q    <= HoldLd;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          strobe_q <= '0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign data_o   = data_q;
  assign strobe_o = strobe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
